// File: rtl/rob_queue.sv
// Reorder buffer: in-order issue into a circular queue, out-of-order completion
// via the CDB, in-order commit with branch-mispredict flush and redirect.
module rob_queue #(
  parameter int unsigned ROB_WIDTH_BIT = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_is_br,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_alt_pc,
  output logic                     full,
  output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  output logic [4:0]               new_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
  input  logic                     cdb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
  input  logic [31:0]              cdb_val,
  input  logic                     cdb_taken,
  input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
  input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
  output logic                     rs1_ready,
  output logic                     rs2_ready,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,
  output logic [4:0]               write_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
  output logic [31:0]              write_val,
  output logic                     clear_flag,
  output logic [31:0]              redirect_pc
);

  localparam int unsigned IW    = ROB_WIDTH_BIT;
  localparam int unsigned CW    = ROB_WIDTH_BIT + 1;
  localparam int unsigned DEPTH = 1 << ROB_WIDTH_BIT;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        is_br;
    logic        pred_taken;
    logic        taken;
    logic [31:0] alt_pc;
  } rob_entry_t;

  rob_entry_t      rob_q [DEPTH];
  logic [IW-1:0]   head_q;
  logic [IW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic            clear_q;
  logic [31:0]     redirect_q;

  rob_entry_t      head_e;
  logic            accept_issue;
  logic            commit_ok;
  logic            mispredict;
  logic            cdb_write;

  // Queue control decisions, all taken from pre-edge state
  assign head_e       = rob_q[head_q];
  assign full         = (count_q == CW'(DEPTH));
  assign accept_issue = issue_valid && !full && !clear_q && rdy_in;
  assign commit_ok    = rdy_in && !clear_q && head_e.busy && head_e.ready;
  assign mispredict   = commit_ok && head_e.is_br && (head_e.taken != head_e.pred_taken);
  assign cdb_write    = rdy_in && !clear_q && cdb_valid && rob_q[cdb_rob_id].busy;

  assign issue_rob_id = tail_q;
  assign new_reg_id   = accept_issue ? issue_rd : 5'd0;
  assign new_ROB_id   = accept_issue ? tail_q : '0;
  assign write_reg_id = commit_ok ? head_e.rd : 5'd0;
  assign write_ROB_id = commit_ok ? head_q : '0;
  assign write_val    = commit_ok ? head_e.val : 32'd0;
  assign clear_flag   = clear_q;
  assign redirect_pc  = redirect_q;

  // Operand lookup: a same-cycle CDB broadcast beats the stored entry
  always_comb begin
    rs1_ready = 1'b0;
    rs1_val   = 32'd0;
    rs2_ready = 1'b0;
    rs2_val   = 32'd0;
    if (cdb_valid && (cdb_rob_id == rs1_id)) begin
      rs1_ready = 1'b1;
      rs1_val   = cdb_val;
    end else if (rob_q[rs1_id].ready) begin
      rs1_ready = 1'b1;
      rs1_val   = rob_q[rs1_id].val;
    end
    if (cdb_valid && (cdb_rob_id == rs2_id)) begin
      rs2_ready = 1'b1;
      rs2_val   = cdb_val;
    end else if (rob_q[rs2_id].ready) begin
      rs2_ready = 1'b1;
      rs2_val   = rob_q[rs2_id].val;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      clear_q    <= 1'b0;
      redirect_q <= 32'd0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rob_q[IW'(i)] <= '0;
      end
    end else if (rdy_in) begin
      clear_q    <= 1'b0;
      redirect_q <= 32'd0;
      if (mispredict) begin
        // Flush wins over any issue or completion in the same cycle
        for (int unsigned i = 0; i < DEPTH; i++) begin
          rob_q[IW'(i)].busy  <= 1'b0;
          rob_q[IW'(i)].ready <= 1'b0;
        end
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        clear_q    <= 1'b1;
        redirect_q <= head_e.alt_pc;
      end else begin
        if (cdb_write) begin
          rob_q[cdb_rob_id].ready <= 1'b1;
          rob_q[cdb_rob_id].val   <= cdb_val;
          rob_q[cdb_rob_id].taken <= cdb_taken;
        end
        if (commit_ok) begin
          rob_q[head_q].busy  <= 1'b0;
          rob_q[head_q].ready <= 1'b0;
          head_q              <= head_q + IW'(1);
        end
        if (accept_issue) begin
          rob_q[tail_q] <= '{busy: 1'b1, ready: 1'b0, rd: issue_rd, val: 32'd0,
                             is_br: issue_is_br, pred_taken: issue_pred_taken,
                             taken: 1'b0, alt_pc: issue_alt_pc};
          tail_q        <= tail_q + IW'(1);
        end
        count_q <= count_q + CW'(accept_issue) - CW'(commit_ok);
      end
    end
  end

endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue: issue/complete/commit, full, forwarding,
// mispredict flush, out-of-order completion, stall and reset.
module tb_rob_queue;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_is_br;
  logic        issue_pred_taken;
  logic [31:0] issue_alt_pc;
  logic        full;
  logic [2:0]  issue_rob_id;
  logic [4:0]  new_reg_id;
  logic [2:0]  new_ROB_id;
  logic        cdb_valid;
  logic [2:0]  cdb_rob_id;
  logic [31:0] cdb_val;
  logic        cdb_taken;
  logic [2:0]  rs1_id;
  logic [2:0]  rs2_id;
  logic        rs1_ready;
  logic        rs2_ready;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  write_reg_id;
  logic [2:0]  write_ROB_id;
  logic [31:0] write_val;
  logic        clear_flag;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  rob_queue #(.ROB_WIDTH_BIT(3)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .full(full), .issue_rob_id(issue_rob_id), .new_reg_id(new_reg_id),
    .new_ROB_id(new_ROB_id), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_val(cdb_val), .cdb_taken(cdb_taken), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id),
    .write_val(write_val), .clear_flag(clear_flag), .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = 5'd0; issue_is_br = 1'b0;
    issue_pred_taken = 1'b0; issue_alt_pc = 32'd0;
    cdb_valid = 1'b0; cdb_rob_id = 3'd0; cdb_val = 32'd0; cdb_taken = 1'b0;
    rs1_id = 3'd0; rs2_id = 3'd0;
  endtask

  // Advance one cycle; inputs are then driven away from the edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0; rdy_in = 1'b1; idle();
    tick();
    rst_n_in = 1'b1;
    settle();
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_rd = rd;
  endtask

  task automatic cdb(input logic [2:0] id, input logic [31:0] v, input logic tk);
    cdb_valid = 1'b1; cdb_rob_id = id; cdb_val = v; cdb_taken = tk;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; idle();
    tick(); tick();
    rst_n_in = 1'b1;
    settle();
    check("rst_full", 32'(full), 0);
    check("rst_issue_id", 32'(issue_rob_id), 0);
    check("rst_write_reg", 32'(write_reg_id), 0);
    check("rst_new_reg", 32'(new_reg_id), 0);
    check("rst_clear", 32'(clear_flag), 0);
    check("rst_redirect", redirect_pc, 0);

    // Basic issue, complete, commit
    issue(5'd5); settle();
    check("iss_new_reg", 32'(new_reg_id), 5);
    check("iss_new_rob", 32'(new_ROB_id), 0);
    tick();
    idle(); cdb(3'd0, 32'h1234, 1'b0); settle();
    check("cdb_no_commit_yet", 32'(write_reg_id), 0);
    tick();
    idle(); settle();
    check("cmt_reg", 32'(write_reg_id), 5);
    check("cmt_val", write_val, 32'h1234);
    check("cmt_rob", 32'(write_ROB_id), 0);
    tick();

    // Fill to full, blocked issue, commit with blocked issue, then issue+commit
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(5'(i + 1)); tick();
    end
    idle(); settle();
    check("full_after_8", 32'(full), 1);
    issue(5'd9); settle();
    check("full_blocks_new_reg", 32'(new_reg_id), 0);
    tick();
    idle(); settle();
    check("full_tail_stays", 32'(issue_rob_id), 0);
    cdb(3'd0, 32'h11, 1'b0); tick();
    idle(); cdb(3'd1, 32'h22, 1'b0); issue(5'd10); settle();
    check("pre_edge_full", 32'(full), 1);
    check("freed_slot_no_issue", 32'(new_reg_id), 0);
    check("commit0_reg", 32'(write_reg_id), 1);
    check("commit0_val", write_val, 32'h11);
    tick();
    idle(); issue(5'd10); settle();
    check("after_commit_not_full", 32'(full), 0);
    check("same_cyc_new_reg", 32'(new_reg_id), 10);
    check("same_cyc_new_rob", 32'(new_ROB_id), 0);
    check("same_cyc_write_reg", 32'(write_reg_id), 2);
    check("same_cyc_write_rob", 32'(write_ROB_id), 1);
    tick();
    idle(); settle();
    check("issue_id_after", 32'(issue_rob_id), 1);
    check("count_kept_not_full", 32'(full), 0);
    issue(5'd11); tick();
    idle(); settle();
    check("refull", 32'(full), 1);

    // CDB forwarding, then lookup from the stored entry
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(5'(i + 1)); tick();
    end
    idle(); cdb(3'd3, 32'hAA, 1'b0); rs1_id = 3'd3; rs2_id = 3'd2; settle();
    check("fwd_rs1_ready", 32'(rs1_ready), 1);
    check("fwd_rs1_val", rs1_val, 32'hAA);
    check("fwd_rs2_ready", 32'(rs2_ready), 0);
    check("fwd_rs2_val", rs2_val, 0);
    tick();
    idle(); rs1_id = 3'd3; rs2_id = 3'd3; settle();
    check("ent_rs1_ready", 32'(rs1_ready), 1);
    check("ent_rs1_val", rs1_val, 32'hAA);
    check("ent_rs2_val", rs2_val, 32'hAA);
    check("head_not_ready", 32'(write_reg_id), 0);

    // Out-of-order completion, in-order commit
    cdb(3'd1, 32'hB1, 1'b0); tick();
    idle(); settle();
    check("ooo_no_commit", 32'(write_reg_id), 0);
    cdb(3'd0, 32'hB0, 1'b0); tick();
    idle(); settle();
    check("ooo_c0_reg", 32'(write_reg_id), 1);
    check("ooo_c0_val", write_val, 32'hB0);
    tick();
    check("ooo_c1_reg", 32'(write_reg_id), 2);
    check("ooo_c1_val", write_val, 32'hB1);
    check("ooo_c1_rob", 32'(write_ROB_id), 1);
    tick();
    check("ooo_stop", 32'(write_reg_id), 0);

    // Mispredicted branch flush
    do_reset();
    issue(5'd7); issue_is_br = 1'b1; issue_pred_taken = 1'b0; issue_alt_pc = 32'h80;
    tick();
    idle(); issue(5'd8); tick();
    idle(); cdb(3'd0, 32'h5, 1'b1); tick();
    idle(); settle();
    check("br_commit_reg", 32'(write_reg_id), 7);
    tick();
    issue(5'd9); cdb(3'd1, 32'h66, 1'b0); settle();
    check("flush_clear", 32'(clear_flag), 1);
    check("flush_redirect", redirect_pc, 32'h80);
    check("flush_issue_id", 32'(issue_rob_id), 0);
    check("flush_new_reg", 32'(new_reg_id), 0);
    check("flush_no_commit", 32'(write_reg_id), 0);
    tick();
    idle(); rs1_id = 3'd1; settle();
    check("clear_one_cycle", 32'(clear_flag), 0);
    check("redirect_gone", redirect_pc, 0);
    check("flush_issue_ignored", 32'(issue_rob_id), 0);
    check("flush_cdb_ignored", 32'(rs1_ready), 0);

    // Stall with pending traffic, then mid-stream reset
    do_reset();
    issue(5'd3); tick();
    idle(); rdy_in = 1'b0; cdb(3'd0, 32'h77, 1'b0); issue(5'd4);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_new_reg", 32'(new_reg_id), 0);
      check("stall_issue_id", 32'(issue_rob_id), 1);
      tick();
    end
    rs1_id = 3'd0; settle();
    check("stall_fwd", 32'(rs1_ready), 1);
    rdy_in = 1'b1; idle(); settle();
    check("stall_cdb_dropped", 32'(write_reg_id), 0);
    check("stall_tail_held", 32'(issue_rob_id), 1);
    cdb(3'd0, 32'h77, 1'b0); tick();
    idle(); settle();
    check("resume_commit", 32'(write_reg_id), 3);
    issue(5'd5); rst_n_in = 1'b0; tick();
    rst_n_in = 1'b1; idle(); settle();
    check("mid_rst_issue_id", 32'(issue_rob_id), 0);
    check("mid_rst_write_reg", 32'(write_reg_id), 0);
    check("mid_rst_new_reg", 32'(new_reg_id), 0);
    check("mid_rst_full", 32'(full), 0);
    check("mid_rst_rs1", 32'(rs1_ready), 0);
    check("mid_rst_clear", 32'(clear_flag), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
